// File: rtl/small_fifo.sv
// rtl/small_fifo.sv - one- or two-entry registered FIFO with synchronous clear
//
// Purpose:
//   A small FIFO holding 1 or 2 entries of 'width' bits. Every output is a
//   flop, so there is no combinational path from any input to any output.
//   The head entry always lives in r_data0, and D_OUT is taken straight from it.
//   When the FIFO drains, D_OUT keeps the last value dequeued.
//
// Parameters:
//   width    data bits per entry (1..64)
//   depth    entry count, 1 or 2
//
// Ports:
//   CLK      clock, rising edge
//   RST_N    synchronous active-low reset; clears count and all data
//   D_IN     enqueue data
//   ENQ      enqueue request, honoured only while FULL_N=1
//   DEQ      dequeue request, honoured only while EMPTY_N=1
//   CLR      synchronous clear of occupancy; data storage is left untouched
//   D_OUT    head-of-queue data
//   FULL_N   high while at least one entry is free
//   EMPTY_N  high while at least one entry is valid

module small_fifo #(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [width-1:0] D_IN,
   input  logic             ENQ,
   input  logic             DEQ,
   input  logic             CLR,
   output logic [width-1:0] D_OUT,
   output logic             FULL_N,
   output logic             EMPTY_N
);

   localparam logic [1:0] L_DEPTH = 2'(depth);

   logic [width-1:0] r_data0;
   logic [width-1:0] r_data1;
   logic [1:0]       r_count;
   logic             r_full_n;
   logic             r_empty_n;

   logic             w_enq;
   logic             w_deq;
   logic [1:0]       w_count_nx;
   logic [width-1:0] w_data0_nx;
   logic [width-1:0] w_data1_nx;

   // Requests are qualified by the registered flags, so a request made
   // against a full or empty queue has no effect at all.
   assign w_enq = ENQ & r_full_n;
   assign w_deq = DEQ & r_empty_n;

   always_comb begin
      w_count_nx = r_count;
      w_data0_nx = r_data0;
      w_data1_nx = r_data1;
      if (CLR) begin
         w_count_nx = 2'd0;
      end else if (w_enq && w_deq) begin
         // Both requests can only be honoured together at depth 2 with one
         // entry. The head leaves and the new word becomes the head.
         w_data0_nx = D_IN;
      end else if (w_enq) begin
         if (r_count == 2'd0) begin
            w_data0_nx = D_IN;
         end else begin
            w_data1_nx = D_IN;
         end
         w_count_nx = 2'(r_count + 2'd1);
      end else if (w_deq) begin
         // The second entry moves up only when there is one. On the last
         // dequeue, r_data0 is held so that D_OUT keeps that value.
         if (r_count == 2'd2) begin
            w_data0_nx = r_data1;
         end
         w_count_nx = 2'(r_count - 2'd1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_data0   <= '0;
         r_data1   <= '0;
         r_count   <= 2'd0;
         r_full_n  <= 1'b1;
         r_empty_n <= 1'b0;
      end else begin
         r_data0   <= w_data0_nx;
         r_data1   <= w_data1_nx;
         r_count   <= w_count_nx;
         r_full_n  <= (w_count_nx < L_DEPTH);
         r_empty_n <= (w_count_nx != 2'd0);
      end
   end

   assign D_OUT   = r_data0;
   assign FULL_N  = r_full_n;
   assign EMPTY_N = r_empty_n;

endmodule

// File: tb/tb_small_fifo.sv
// tb/tb_small_fifo.sv - directed self-checking bench for small_fifo at depth 2 and depth 1

module tb_small_fifo;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] d2_in, d2_out;
   logic       d2_enq, d2_deq, d2_clr, d2_full_n, d2_empty_n;
   logic [7:0] d1_in, d1_out;
   logic       d1_enq, d1_deq, d1_clr, d1_full_n, d1_empty_n;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   small_fifo #(.width(8), .depth(2)) u_d2 (
      .CLK(clk), .RST_N(rst_n), .D_IN(d2_in), .ENQ(d2_enq), .DEQ(d2_deq),
      .CLR(d2_clr), .D_OUT(d2_out), .FULL_N(d2_full_n), .EMPTY_N(d2_empty_n)
   );

   small_fifo #(.width(8), .depth(1)) u_d1 (
      .CLK(clk), .RST_N(rst_n), .D_IN(d1_in), .ENQ(d1_enq), .DEQ(d1_deq),
      .CLR(d1_clr), .D_OUT(d1_out), .FULL_N(d1_full_n), .EMPTY_N(d1_empty_n)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic d2_drive(input logic enq, input logic deq, input logic clr, input logic [7:0] d);
      d2_enq = enq; d2_deq = deq; d2_clr = clr; d2_in = d;
   endtask

   task automatic d1_drive(input logic enq, input logic deq, input logic clr, input logic [7:0] d);
      d1_enq = enq; d1_deq = deq; d1_clr = clr; d1_in = d;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      d2_drive(1'b1, 1'b1, 1'b0, 8'hFF);
      d1_drive(1'b1, 1'b0, 1'b0, 8'hFF);
      tick();
      rst_n = 1'b1;
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
      d1_drive(1'b0, 1'b0, 1'b0, 8'h00);
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_d2 got full_n=%b empty_n=%b dout=%h exp 1 0 00", d2_full_n, d2_empty_n, d2_out);
      end
      n_tests++;
      if ({d1_full_n, d1_empty_n, d1_out} !== {1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_d1 got full_n=%b empty_n=%b dout=%h exp 1 0 00", d1_full_n, d1_empty_n, d1_out);
      end
   endtask

   task automatic test_d2_basic;
      d2_drive(1'b1, 1'b0, 1'b0, 8'h11); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b1, 8'h11}) begin
         n_fail++;
         $display("FAIL d2_enq1 got %b %b %h exp 1 1 11", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b1, 1'b0, 1'b0, 8'h22); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b0, 1'b1, 8'h11}) begin
         n_fail++;
         $display("FAIL d2_enq2_full got %b %b %h exp 0 1 11", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b1, 1'b0, 1'b0, 8'h33); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b0, 1'b1, 8'h11}) begin
         n_fail++;
         $display("FAIL d2_enq_when_full got %b %b %h exp 0 1 11", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b1, 8'h22}) begin
         n_fail++;
         $display("FAIL d2_deq1 got %b %b %h exp 1 1 22", d2_full_n, d2_empty_n, d2_out);
      end
      tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h22}) begin
         n_fail++;
         $display("FAIL d2_deq2_empty got %b %b %h exp 1 0 22", d2_full_n, d2_empty_n, d2_out);
      end
      tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h22}) begin
         n_fail++;
         $display("FAIL d2_deq_on_empty got %b %b %h exp 1 0 22", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_simultaneous;
      d2_drive(1'b1, 1'b0, 1'b0, 8'hA5); tick();
      d2_drive(1'b1, 1'b1, 1'b0, 8'h5A); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b1, 8'h5A}) begin
         n_fail++;
         $display("FAIL d2_enq_deq_one got %b %b %h exp 1 1 5A", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h5A}) begin
         n_fail++;
         $display("FAIL d2_enq_deq_count1 got %b %b %h exp 1 0 5A", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b1, 1'b1, 1'b0, 8'hC3); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b1, 8'hC3}) begin
         n_fail++;
         $display("FAIL d2_enq_deq_empty got %b %b %h exp 1 1 C3", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_order_full;
      d2_drive(1'b1, 1'b0, 1'b0, 8'h10); tick();
      d2_drive(1'b1, 1'b0, 1'b0, 8'h20); tick();
      d2_drive(1'b1, 1'b1, 1'b0, 8'h30); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b1, 8'h20}) begin
         n_fail++;
         $display("FAIL d2_enq_deq_full got %b %b %h exp 1 1 20", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b1, 1'b0, 1'b0, 8'h40); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b0, 1'b1, 8'h20}) begin
         n_fail++;
         $display("FAIL d2_refill got %b %b %h exp 0 1 20", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b1, 8'h40}) begin
         n_fail++;
         $display("FAIL d2_order_40 got %b %b %h exp 1 1 40", d2_full_n, d2_empty_n, d2_out);
      end
      tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h40}) begin
         n_fail++;
         $display("FAIL d2_order_drain got %b %b %h exp 1 0 40", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_clear;
      d2_drive(1'b1, 1'b0, 1'b0, 8'h01); tick();
      d2_drive(1'b1, 1'b0, 1'b0, 8'h02); tick();
      d2_drive(1'b1, 1'b1, 1'b1, 8'h44); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h01}) begin
         n_fail++;
         $display("FAIL d2_clr got %b %b %h exp 1 0 01", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b1, 1'b0, 1'b0, 8'h44); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b1, 8'h44}) begin
         n_fail++;
         $display("FAIL d2_enq_after_clr got %b %b %h exp 1 1 44", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h44}) begin
         n_fail++;
         $display("FAIL d2_clr_drain got %b %b %h exp 1 0 44", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid;
      d2_drive(1'b1, 1'b0, 1'b0, 8'h66); tick();
      d2_drive(1'b1, 1'b0, 1'b0, 8'h77); tick();
      rst_n = 1'b0;
      d2_drive(1'b1, 1'b1, 1'b1, 8'h88); tick();
      rst_n = 1'b1;
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL d2_reset_mid got %b %b %h exp 1 0 00", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b1, 1'b0, 1'b0, 8'h99); tick();
      d2_drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      n_tests++;
      if ({d2_full_n, d2_empty_n, d2_out} !== {1'b1, 1'b0, 8'h99}) begin
         n_fail++;
         $display("FAIL d2_after_reset_single got %b %b %h exp 1 0 99", d2_full_n, d2_empty_n, d2_out);
      end
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_depth1;
      d1_drive(1'b1, 1'b0, 1'b0, 8'h7E); tick();
      n_tests++;
      if ({d1_full_n, d1_empty_n, d1_out} !== {1'b0, 1'b1, 8'h7E}) begin
         n_fail++;
         $display("FAIL d1_enq got %b %b %h exp 0 1 7E", d1_full_n, d1_empty_n, d1_out);
      end
      d1_drive(1'b1, 1'b0, 1'b0, 8'h01); tick();
      n_tests++;
      if ({d1_full_n, d1_empty_n, d1_out} !== {1'b0, 1'b1, 8'h7E}) begin
         n_fail++;
         $display("FAIL d1_enq_when_full got %b %b %h exp 0 1 7E", d1_full_n, d1_empty_n, d1_out);
      end
      d1_drive(1'b1, 1'b1, 1'b0, 8'h02); tick();
      n_tests++;
      if ({d1_full_n, d1_empty_n, d1_out} !== {1'b1, 1'b0, 8'h7E}) begin
         n_fail++;
         $display("FAIL d1_deq_full got %b %b %h exp 1 0 7E", d1_full_n, d1_empty_n, d1_out);
      end
      d1_drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
      n_tests++;
      if ({d1_full_n, d1_empty_n, d1_out} !== {1'b1, 1'b0, 8'h7E}) begin
         n_fail++;
         $display("FAIL d1_deq_on_empty got %b %b %h exp 1 0 7E", d1_full_n, d1_empty_n, d1_out);
      end
      d1_drive(1'b1, 1'b1, 1'b0, 8'h03); tick();
      n_tests++;
      if ({d1_full_n, d1_empty_n, d1_out} !== {1'b0, 1'b1, 8'h03}) begin
         n_fail++;
         $display("FAIL d1_enq_deq_empty got %b %b %h exp 0 1 03", d1_full_n, d1_empty_n, d1_out);
      end
      d1_drive(1'b1, 1'b0, 1'b1, 8'h04); tick();
      n_tests++;
      if ({d1_full_n, d1_empty_n, d1_out} !== {1'b1, 1'b0, 8'h03}) begin
         n_fail++;
         $display("FAIL d1_clr got %b %b %h exp 1 0 03", d1_full_n, d1_empty_n, d1_out);
      end
      d1_drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0;
      d2_drive(1'b0, 1'b0, 1'b0, 8'h00);
      d1_drive(1'b0, 1'b0, 1'b0, 8'h00);
      test_reset();
      test_d2_basic();
      test_simultaneous();
      test_order_full();
      test_clear();
      test_reset_mid();
      test_depth1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
